// File: rtl/prv_trap_ctrl.sv
// prv_trap_ctrl
// -----------------------------------------------------------------------------
// Trap sequencer that sits between the pipeline hazard unit and the machine
// CSR file. It selects the highest-priority trap source, runs the flush
// handshake with the hazard unit, and produces a one-cycle redirect. The
// redirect target is either the trap vector (direct or vectored) or mepc for
// mret. It also owns mcause/mepc/mtval and the MIE/MPIE bits, and parks fetch
// while a wfi is outstanding.
//
// Ports
//   CLK, RST        clock, synchronous active-high reset
//   exc_valid       WB instruction retiring; qualifies exc_std/exc_ext/ret/wfi
//   exc_std[15:0]   standard exception flags, bit index = cause code
//   exc_ext         extension exception flags, cause code = 24 + index
//   exc_pc          PC of the WB instruction (saved to mepc on any trap)
//   exc_tval        faulting address / instruction (saved to mtval)
//   intr_pend       pending interrupts (mip), cause code = index
//   intr_en         interrupt enables (mie)
//   ret, wfi        mret / wfi retiring
//   pipe_clear      hazard unit reports the pipeline is drained
//   xtvec           trap vector base, [1:0] = mode (01 = vectored)
//   intr            flush request, high for the whole FLUSH phase
//   insert_pc       one-cycle redirect strobe, priv_pc valid with it
//   priv_pc         redirect target
//   wfi_stall       hold fetch while sleeping
//   mcause/mepc/mtval, mstatus_mie/mstatus_mpie   CSR state
// -----------------------------------------------------------------------------
module prv_trap_ctrl #(
  parameter int XLEN     = 32,
  parameter int NUM_EXT  = 4,
  parameter int NUM_INTR = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                exc_valid,
  input  logic [15:0]         exc_std,
  input  logic [NUM_EXT-1:0]  exc_ext,
  input  logic [XLEN-1:0]     exc_pc,
  input  logic [XLEN-1:0]     exc_tval,
  input  logic [NUM_INTR-1:0] intr_pend,
  input  logic [NUM_INTR-1:0] intr_en,
  input  logic                ret,
  input  logic                wfi,
  input  logic                pipe_clear,
  input  logic [XLEN-1:0]     xtvec,
  output logic                intr,
  output logic                insert_pc,
  output logic [XLEN-1:0]     priv_pc,
  output logic                wfi_stall,
  output logic [XLEN-1:0]     mcause,
  output logic [XLEN-1:0]     mepc,
  output logic [XLEN-1:0]     mtval,
  output logic                mstatus_mie,
  output logic                mstatus_mpie
);

  // Cause code field: everything below the interrupt flag.
  localparam int CW   = XLEN - 1;
  // Interrupt vector padded so the fixed high-priority indices (up to 11)
  // can always be addressed, even for small NUM_INTR.
  localparam int IPAD = (NUM_INTR > 12) ? NUM_INTR : 12;

  // Standard exception order, highest priority in the top nibble.
  localparam logic [63:0] EXC_ORDER     = 64'h3C10_289B_46DF_57AE;
  // Preferred interrupts, lowest of the six in the bottom nibble:
  // 5,1,9,7,3,11 (so 11 is the highest).
  localparam logic [23:0] INTR_HI_ORDER = 24'hB3_7915;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_REDIRECT,
    S_SLEEP
  } state_t;

  state_t          state_q, state_d;
  logic            is_intr_q, is_intr_d;
  logic            is_ret_q, is_ret_d;
  logic [CW-1:0]   code_q, code_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic [XLEN-1:0] tvec_q, tvec_d;
  logic [XLEN-1:0] priv_pc_q, priv_pc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic            mie_q, mie_d;
  logic            mpie_q, mpie_d;

  logic [NUM_INTR-1:0] intr_masked;
  logic [IPAD-1:0]     intr_pad;
  logic                intr_any;
  logic                exc_any;
  logic [CW-1:0]       intr_code;
  logic [CW-1:0]       exc_code;
  logic [3:0]          exc_pick;
  logic [3:0]          intr_pick;

  assign intr_masked = intr_pend & intr_en;
  assign intr_any    = |intr_masked;
  assign exc_any     = exc_valid & ((|exc_std) | (|exc_ext));

  // Priority encoders. Each loop walks from lowest to highest priority so
  // the last hit wins.
  always_comb begin
    intr_pad  = IPAD'(intr_masked);
    intr_code = '0;
    intr_pick = '0;
    // Remaining interrupts: descending index order.
    for (int i = 0; i < IPAD; i++) begin
      if (intr_pad[i]) intr_code = CW'(i);
    end
    // Preferred interrupts override the descending order.
    for (int k = 0; k < 6; k++) begin
      intr_pick = INTR_HI_ORDER[4*k +: 4];
      if (intr_pad[intr_pick]) intr_code = CW'(intr_pick);
    end

    exc_code = '0;
    exc_pick = '0;
    // Extension lines rank below every standard exception; ext[0] first.
    for (int i = NUM_EXT - 1; i >= 0; i--) begin
      if (exc_ext[i]) exc_code = CW'(24 + i);
    end
    for (int k = 15; k >= 0; k--) begin
      exc_pick = EXC_ORDER[63 - 4*k -: 4];
      if (exc_std[exc_pick]) exc_code = CW'(exc_pick);
    end
  end

  logic            take_intr;
  logic            take_exc;
  logic [XLEN-1:0] trap_target;

  always_comb begin
    state_d   = state_q;
    is_intr_d = is_intr_q;
    is_ret_d  = is_ret_q;
    code_d    = code_q;
    pc_d      = pc_q;
    tval_d    = tval_q;
    tvec_d    = tvec_q;
    priv_pc_d = priv_pc_q;
    mcause_d  = mcause_q;
    mepc_d    = mepc_q;
    mtval_d   = mtval_q;
    mie_d     = mie_q;
    mpie_d    = mpie_q;
    take_intr = 1'b0;
    take_exc  = 1'b0;

    // Reserved mode 1x falls through to direct; only interrupts vector.
    trap_target = {tvec_q[XLEN-1:2], 2'b00};
    if (is_intr_q && (tvec_q[1:0] == 2'b01)) begin
      trap_target = trap_target + {code_q[XLEN-3:0], 2'b00};
    end

    case (state_q)
      S_IDLE: begin
        if (intr_any && mie_q) begin
          take_intr = 1'b1;
        end else if (exc_any) begin
          take_exc = 1'b1;
        end else if (exc_valid && ret) begin
          is_ret_d  = 1'b1;
          is_intr_d = 1'b0;
          state_d   = S_FLUSH;
        end else if (exc_valid && wfi) begin
          state_d = S_SLEEP;
        end
      end
      S_SLEEP: begin
        // Wake on any enabled pending line; only trap if globally enabled.
        if (intr_any) begin
          if (mie_q) take_intr = 1'b1;
          else       state_d   = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (pipe_clear) begin
          state_d   = S_REDIRECT;
          priv_pc_d = is_ret_q ? mepc_q : trap_target;
        end
      end
      S_REDIRECT: begin
        state_d = S_IDLE;
        if (is_ret_q) begin
          mie_d  = mpie_q;
          mpie_d = 1'b1;
        end else begin
          mcause_d = {is_intr_q, code_q};
          mepc_d   = pc_q;
          mtval_d  = is_intr_q ? '0 : tval_q;
          mpie_d   = mie_q;
          mie_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Snapshot everything the redirect needs so later input changes during
    // FLUSH/REDIRECT cannot disturb the trap in flight.
    if (take_intr || take_exc) begin
      state_d   = S_FLUSH;
      is_ret_d  = 1'b0;
      is_intr_d = take_intr;
      code_d    = take_intr ? intr_code : exc_code;
      pc_d      = exc_pc;
      tval_d    = exc_tval;
      tvec_d    = xtvec;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      is_intr_q <= 1'b0;
      is_ret_q  <= 1'b0;
      code_q    <= '0;
      pc_q      <= '0;
      tval_q    <= '0;
      tvec_q    <= '0;
      priv_pc_q <= '0;
      mcause_q  <= '0;
      mepc_q    <= '0;
      mtval_q   <= '0;
      mie_q     <= 1'b0;
      mpie_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      is_intr_q <= is_intr_d;
      is_ret_q  <= is_ret_d;
      code_q    <= code_d;
      pc_q      <= pc_d;
      tval_q    <= tval_d;
      tvec_q    <= tvec_d;
      priv_pc_q <= priv_pc_d;
      mcause_q  <= mcause_d;
      mepc_q    <= mepc_d;
      mtval_q   <= mtval_d;
      mie_q     <= mie_d;
      mpie_q    <= mpie_d;
    end
  end

  assign intr         = (state_q == S_FLUSH);
  assign insert_pc    = (state_q == S_REDIRECT);
  assign wfi_stall    = (state_q == S_SLEEP);
  assign priv_pc      = priv_pc_q;
  assign mcause       = mcause_q;
  assign mepc         = mepc_q;
  assign mtval        = mtval_q;
  assign mstatus_mie  = mie_q;
  assign mstatus_mpie = mpie_q;

endmodule
